sine_nco_sequencer: RTL

//  Numerically controlled oscillator front end that sequences a single shared combinational sine LUT.
//  A phase accumulator drives the LUT address, and the LUT is time-multiplexed to produce a sin sample
//  and a cos sample (quarter-wave address offset) per output beat.

---
 rtl/sine_nco_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/sine_nco_sequencer.sv
// Phase-accumulator NCO that time-shares one external sine LUT to produce a
// sin/cos sample pair every beat, delivered on a valid/ready stream.
module sine_nco_sequencer #(
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_DEPTH   = 8,
  parameter int DATA_WIDTH  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   phase_clear,
  input  logic [PHASE_WIDTH-1:0] phase_inc_in,
  input  logic                   phase_inc_load,
  output logic [LUT_DEPTH-1:0]   lut_addr,
  input  logic [DATA_WIDTH-1:0]  lut_data,
  output logic [DATA_WIDTH-1:0]  sin_out,
  output logic [DATA_WIDTH-1:0]  cos_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  typedef enum logic [1:0] {IDLE, SIN, COS, HOLD} state_t;

  localparam logic [LUT_DEPTH-1:0] QUARTER = LUT_DEPTH'(1) << (LUT_DEPTH - 2);

  state_t                  state, state_nxt;
  logic [PHASE_WIDTH-1:0]  phase_acc;
  logic [PHASE_WIDTH-1:0]  phase_inc;
  logic [LUT_DEPTH-1:0]    addr_s;
  logic [LUT_DEPTH-1:0]    addr_c;
  logic signed [DATA_WIDTH-1:0] sin_p0;

  // Cosine is the same table read a quarter period ahead; the add wraps mod table size.
  assign addr_s = phase_acc[PHASE_WIDTH-1 -: LUT_DEPTH];
  assign addr_c = addr_s + QUARTER;

  always_comb begin
    state_nxt = state;
    lut_addr  = addr_s;
    out_valid = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = SIN;
      SIN:  state_nxt = COS;
      COS: begin
        lut_addr  = addr_c;
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = enable ? SIN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (phase_clear) state_nxt = IDLE;
  end

  // Stage p0: first LUT read of the beat is parked until the cos read completes.
  always_ff @(posedge clk) begin
    if (state == SIN) sin_p0 <= lut_data;
  end

  // Stage p1: pair published and phase advanced together on the COS beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase_acc <= '0;
      phase_inc <= '0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      state <= state_nxt;
      if (phase_inc_load) phase_inc <= phase_inc_in;
      if (phase_clear) begin
        phase_acc <= '0;
      end else if (state == COS) begin
        phase_acc <= phase_acc + phase_inc;
        sin_out   <= sin_p0;
        cos_out   <= lut_data;
      end
    end
  end

endmodule
